// File: rtl/dll_tune_ctrl.sv
// -----------------------------------------------------------------------------
// dll_tune_ctrl
// Delay-code tuning controller for the FMDLL loop. After a start request it
// runs a binary (SAR) search on the coarse delay code, then an up/down
// tracking loop on the fine delay code, and declares lock once enough
// qualifying fine samples have been seen. Every code write is followed by a
// settle window during which the phase detector is held in reset.
//
// Optional feature macro: DLL_LOCK_MON_EN
//   When defined, a sample in LOCK that leaves the fine code saturated
//   (0 or all-ones) drops lock and restarts the coarse search.
//
// Ports:
//   clk2        in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   one-cycle request that starts/restarts tuning
//   up          in   PD decision: delay too small
//   dn          in   PD decision: delay too large
//   hld1        in   freeze the coarse search (only while in COARSE)
//   hld2        in   freeze fine tracking (only while in FINE/LOCK)
//   coarse_code out  coarse delay code [CW-1:0]
//   fine_code   out  fine delay code [FW-1:0]
//   pd_rst      out  phase-detector reset, high while the line settles
//   state       out  IDLE=0, COARSE=1, FINE=2, LOCK=3
//   lock        out  loop locked
// -----------------------------------------------------------------------------
module dll_tune_ctrl #(
   parameter int CW       = 4,
   parameter int FW       = 4,
   parameter int SETTLE   = 3,
   parameter int LOCK_CNT = 8
) (
   input  logic          clk2,
   input  logic          rst_n,
   input  logic          start,
   input  logic          up,
   input  logic          dn,
   input  logic          hld1,
   input  logic          hld2,
   output logic [CW-1:0] coarse_code,
   output logic [FW-1:0] fine_code,
   output logic          pd_rst,
   output logic [1:0]    state,
   output logic          lock
);

   localparam int IDX_W    = (CW > 1) ? $clog2(CW) : 1;
   localparam int SETTLE_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int LC_W     = $clog2(LOCK_CNT + 1);

   localparam logic [CW-1:0]       COARSE_INIT = CW'(1) << (CW - 1);
   localparam logic [FW-1:0]       FINE_MID    = FW'(1) << (FW - 1);
   localparam logic [FW-1:0]       FINE_MAX    = {FW{1'b1}};
   localparam logic [IDX_W-1:0]    IDX_TOP     = IDX_W'(CW - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LD   = SETTLE_W'(SETTLE);
   localparam logic [LC_W-1:0]     LC_TARGET   = LC_W'(LOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COARSE = 2'd1,
      ST_FINE   = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

   state_t              state_reg,    state_next;
   logic [CW-1:0]       coarse_reg,   coarse_next;
   logic [FW-1:0]       fine_reg,     fine_next;
   logic [IDX_W-1:0]    idx_reg,      idx_next;
   logic [SETTLE_W-1:0] settle_reg,   settle_next;
   logic [LC_W-1:0]     lock_cnt_reg, lock_cnt_next;
   dir_t                dir_reg,      dir_next;
   logic                lock_reg,     lock_next;

   dir_t sample_dir;
   logic frozen;
   logic qualify;
   logic restart;

   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         coarse_reg   <= '0;
         fine_reg     <= FINE_MID;
         idx_reg      <= IDX_TOP;
         settle_reg   <= '0;
         lock_cnt_reg <= '0;
         dir_reg      <= DIR_NONE;
         lock_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         coarse_reg   <= coarse_next;
         fine_reg     <= fine_next;
         idx_reg      <= idx_next;
         settle_reg   <= settle_next;
         lock_cnt_reg <= lock_cnt_next;
         dir_reg      <= dir_next;
         lock_reg     <= lock_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      coarse_next   = coarse_reg;
      fine_next     = fine_reg;
      idx_next      = idx_reg;
      settle_next   = settle_reg;
      lock_cnt_next = lock_cnt_reg;
      dir_next      = dir_reg;
      lock_next     = lock_reg;
      restart       = start;
      qualify       = 1'b0;

      // Both or neither asserted is a "no direction" sample.
      sample_dir = DIR_NONE;
      if (up && !dn) begin
         sample_dir = DIR_UP;
      end else if (dn && !up) begin
         sample_dir = DIR_DN;
      end

      // A hold only acts in the phase it belongs to.
      frozen = ((state_reg == ST_COARSE) && hld1) ||
               (((state_reg == ST_FINE) || (state_reg == ST_LOCK)) && hld2);

      if (!start && (state_reg != ST_IDLE) && !frozen) begin
         if (settle_reg != '0) begin
            settle_next = settle_reg - 1'b1;
         end else begin
            // Sample cycle: every sample ends in a new settle window.
            settle_next = SETTLE_LD;
            if (state_reg == ST_COARSE) begin
               // The bit under test is always set; clear it when too long.
               if (sample_dir == DIR_DN) begin
                  coarse_next[idx_reg] = 1'b0;
               end
               if (idx_reg == '0) begin
                  state_next = ST_FINE;
               end else begin
                  idx_next                       = idx_reg - 1'b1;
                  coarse_next[idx_reg - 1'b1]    = 1'b1;
               end
            end else begin
               if ((sample_dir == DIR_UP) && (fine_reg != FINE_MAX)) begin
                  fine_next = fine_reg + 1'b1;
               end else if ((sample_dir == DIR_DN) && (fine_reg != '0)) begin
                  fine_next = fine_reg - 1'b1;
               end

               // Dithering (direction reversals) or no-direction samples mean
               // the loop sits at the edge; a repeat means it is still moving.
               qualify = (sample_dir == DIR_NONE) || (dir_reg == DIR_NONE) ||
                         (sample_dir != dir_reg);
               if (qualify) begin
                  if (lock_cnt_reg != LC_TARGET) begin
                     lock_cnt_next = lock_cnt_reg + 1'b1;
                  end
               end else begin
                  lock_cnt_next = '0;
               end
               if (sample_dir != DIR_NONE) begin
                  dir_next = sample_dir;
               end

               if ((state_reg == ST_FINE) && (lock_cnt_next == LC_TARGET)) begin
                  state_next = ST_LOCK;
                  lock_next  = 1'b1;
               end
`ifdef DLL_LOCK_MON_EN
               if ((state_reg == ST_LOCK) &&
                   ((fine_next == '0) || (fine_next == FINE_MAX))) begin
                  restart = 1'b1;
               end
`endif
            end
         end
      end

      // A restart also forgets the previous direction so the first fine
      // sample of a new search is never counted as a repeat.
      if (restart) begin
         state_next    = ST_COARSE;
         coarse_next   = COARSE_INIT;
         idx_next      = IDX_TOP;
         fine_next     = FINE_MID;
         lock_next     = 1'b0;
         lock_cnt_next = '0;
         dir_next      = DIR_NONE;
         settle_next   = SETTLE_LD;
      end
   end

   assign coarse_code = coarse_reg;
   assign fine_code   = fine_reg;
   assign pd_rst      = (state_reg == ST_IDLE) || (settle_reg != '0);
   assign state       = state_reg;
   assign lock        = lock_reg;

endmodule

// File: tb/tb_dll_tune_ctrl.sv
module tb_dll_tune_ctrl;

   localparam int CW       = 4;
   localparam int FW       = 4;
   localparam int SETTLE   = 3;
   localparam int LOCK_CNT = 8;
   localparam int FMAX     = (1 << FW) - 1;
   localparam int FMID     = 1 << (FW - 1);

   logic          clk2 = 1'b0;
   logic          rst_n, start, up, dn, hld1, hld2;
   logic [CW-1:0] coarse_code;
   logic [FW-1:0] fine_code;
   logic          pd_rst;
   logic [1:0]    state;
   logic          lock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: step-level view of the tuning loop.
   int m_state, m_coarse, m_fine, m_idx, m_wait, m_lcnt, m_prev, m_lock;
   bit m_fine_sample;

   always #5 clk2 = ~clk2;

   dll_tune_ctrl #(.CW(CW), .FW(FW), .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT)) dut (
      .clk2        (clk2),
      .rst_n       (rst_n),
      .start       (start),
      .up          (up),
      .dn          (dn),
      .hld1        (hld1),
      .hld2        (hld2),
      .coarse_code (coarse_code),
      .fine_code   (fine_code),
      .pd_rst      (pd_rst),
      .state       (state),
      .lock        (lock)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_coarse = 0; m_fine = FMID; m_idx = CW - 1;
      m_wait = 0; m_lcnt = 0; m_prev = 0; m_lock = 0;
   endtask

   task automatic model_restart();
      m_state = 1; m_coarse = 1 << (CW - 1); m_idx = CW - 1;
      m_fine = FMID; m_lock = 0; m_lcnt = 0; m_prev = 0; m_wait = SETTLE;
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_step();
      int d;
      m_fine_sample = 1'b0;
      d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
      if (start) begin
         model_restart();
      end else if (m_state != 0 && !(m_state == 1 && hld1) && !(m_state >= 2 && hld2)) begin
         if (m_wait > 0) begin
            m_wait--;
         end else begin
            m_wait = SETTLE;
            if (m_state == 1) begin
               if (d == -1) m_coarse -= (1 << m_idx);
               if (m_idx == 0) begin
                  m_state = 2;
               end else begin
                  m_idx--;
                  m_coarse += (1 << m_idx);
               end
            end else begin
               m_fine_sample = 1'b1;
               m_fine += d;
               if (m_fine < 0) m_fine = 0;
               if (m_fine > FMAX) m_fine = FMAX;
               if (d == 0 || m_prev == 0 || d == -m_prev) begin
                  if (m_lcnt < LOCK_CNT) m_lcnt++;
               end else begin
                  m_lcnt = 0;
               end
               if (d != 0) m_prev = d;
               if (m_state == 2 && m_lcnt >= LOCK_CNT) begin
                  m_state = 3;
                  m_lock  = 1;
               end else if (m_state == 3 && (m_fine == 0 || m_fine == FMAX)) begin
`ifdef DLL_LOCK_MON_EN
                  model_restart();
`endif
               end
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_coarse"}, int'(coarse_code), m_coarse);
      check({tag, "_fine"},   int'(fine_code),   m_fine);
      check({tag, "_pd_rst"}, int'(pd_rst),      (m_state == 0 || m_wait != 0) ? 1 : 0);
      check({tag, "_state"},  int'(state),       m_state);
      check({tag, "_lock"},   int'(lock),        m_lock);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk2);
      model_step();
      #1;
      compare_all(tag);
   endtask

   // PD that reports "too long" whenever the coarse code exceeds target.
   task automatic drive_coarse_rule(input int target);
      dn = (m_coarse > target);
      up = !dn;
   endtask

   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, "_coarse"}, int'(coarse_code), 0);
      check({tag, "_fine"},   int'(fine_code),   FMID);
      check({tag, "_pd_rst"}, int'(pd_rst),      1);
      check({tag, "_state"},  int'(state),       0);
      check({tag, "_lock"},   int'(lock),        0);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int seq[$];
      int samples;
      int budget;
      rst_n = 1'b0; start = 1'b0; up = 1'b0; dn = 1'b0; hld1 = 1'b0; hld2 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk2);
      #1;
      compare_all("reset");
      rst_n = 1'b1;
      cycle("idle");

      // Coarse search towards 10, completes 16 edges after start.
      start = 1'b1;
      cycle("start");
      start = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         drive_coarse_rule(10);
         cycle("coarse");
         if (i == 15) check("coarse_pre_done_state", int'(state), 1);
      end
      check("coarse_done_state", int'(state), 2);
      check("coarse_done_code", int'(coarse_code), 10);
      $display("txn coarse_search: code=%0d state=%0d", coarse_code, state);

      // Fine saturation with up held.
      up = 1'b1; dn = 1'b0;
      for (int i = 0; i < 7 * (SETTLE + 1); i++) cycle("fine_up");
      check("fine_sat_code", int'(fine_code), FMAX);
      for (int i = 0; i < 3 * (SETTLE + 1); i++) cycle("fine_up_hold");
      check("fine_sat_stay", int'(fine_code), FMAX);
      check("fine_sat_lock", int'(lock), 0);
      $display("txn fine_saturation: fine=%0d lock=%0d", fine_code, lock);

      // Restart, then fine sequence with a repeat that clears the count.
      start = 1'b1;
      cycle("restart");
      start = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         drive_coarse_rule(10);
         cycle("coarse2");
      end
      seq = '{1, -1, 1, 1, -1, 1, -1, 1, -1, 1, -1, 1};
      budget = 200;
      while (seq.size() > 0 && budget > 0) begin
         up = (seq[0] == 1); dn = (seq[0] == -1);
         cycle("lockseq");
         budget--;
         if (m_fine_sample) begin
            void'(seq.pop_front());
            if (seq.size() == 1) check("lock_before_8th", int'(lock), 0);
         end
      end
      check("lockseq_budget", (budget > 0) ? 1 : 0, 1);
      check("lock_on_8th", int'(lock), 1);
      check("lock_state", int'(state), 3);
      $display("txn lock: fine=%0d lock=%0d state=%0d", fine_code, lock, state);

      // Drive dn in LOCK until the fine code bottoms out (10 -> 0).
      up = 1'b0; dn = 1'b1;
      samples = 0; budget = 200;
      while (samples < 10 && budget > 0) begin
         cycle("mon");
         budget--;
         if (m_fine_sample) samples++;
      end
      check("mon_budget", (budget > 0) ? 1 : 0, 1);
`ifdef DLL_LOCK_MON_EN
      check("mon_lock", int'(lock), 0);
      check("mon_state", int'(state), 1);
      check("mon_coarse", int'(coarse_code), 8);
`else
      check("mon_lock", int'(lock), 1);
      check("mon_state", int'(state), 3);
      check("mon_fine", int'(fine_code), 0);
`endif
      $display("txn lock_monitor: lock=%0d state=%0d", lock, state);

      // Coarse hold for 10 cycles in the second step.
      dn = 1'b0; up = 1'b0;
      start = 1'b1;
      cycle("hold_start");
      start = 1'b0;
      for (int i = 1; i <= 26; i++) begin
         hld1 = (i >= 6 && i <= 15);
         drive_coarse_rule(10);
         cycle("hold");
         if (i == 10) begin
            check("hold_coarse_frozen", int'(coarse_code), 12);
            check("hold_pd_rst_frozen", int'(pd_rst), 1);
         end
         if (i == 25) check("hold_pre_done_state", int'(state), 1);
      end
      hld1 = 1'b0;
      check("hold_done_state", int'(state), 2);
      check("hold_done_code", int'(coarse_code), 10);
      $display("txn coarse_hold: code=%0d state=%0d", coarse_code, state);

      // start during hld1 restarts immediately.
      start = 1'b1;
      cycle("rs");
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_coarse_rule(10);
         cycle("rs_run");
      end
      hld1 = 1'b1;
      cycle("rs_hold");
      start = 1'b1;
      cycle("rs_hold_start");
      start = 1'b0;
      check("hold_start_state", int'(state), 1);
      check("hold_start_coarse", int'(coarse_code), 8);
      check("hold_start_pd_rst", int'(pd_rst), 1);
      hld1 = 1'b0;
      for (int i = 0; i < 3; i++) cycle("pre_rst");
      async_reset("async_rst");
      $display("txn async_reset: state=%0d coarse=%0d", state, coarse_code);
      cycle("post_rst");

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 149) == 0);
         up    = $urandom_range(0, 1) == 1;
         dn    = $urandom_range(0, 1) == 1;
         hld1  = ($urandom_range(0, 5) == 0);
         hld2  = ($urandom_range(0, 5) == 0);
         cycle("rand");
         if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
      end
      $display("txn random: done state=%0d lock=%0d", state, lock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
